// File: rtl/imem_pkg.sv
// Shared types and helpers for the instruction-memory responder.
package imem_pkg;

  typedef enum logic {
    IDLE,
    FETCH
  } state_t;

  localparam int WORD_BYTES = 4;

  localparam logic [1:0] LANE0 = 2'd0;
  localparam logic [1:0] LANE1 = 2'd1;
  localparam logic [1:0] LANE2 = 2'd2;
  localparam logic [1:0] LANE3 = 2'd3;

  // Little-endian placement: lane 0 is bits [7:0], lane 3 is bits [31:24].
  function automatic logic [31:0] placeByte(input logic [31:0] word,
                                            input logic [1:0]  lane,
                                            input logic [7:0]  data);
    logic [31:0] result;
    result = word;
    case (lane)
      LANE0: result[7:0]   = data;
      LANE1: result[15:8]  = data;
      LANE2: result[23:16] = data;
      LANE3: result[31:24] = data;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/imem_byte_array.sv
// Byte-wide program storage: synchronous load write, combinational fetch read.
// Contents are deliberately left out of reset so a loaded program survives it.
module imem_byte_array
  import imem_pkg::*;
#(
  parameter int DEPTH_BYTES = 1024,
  parameter int AW          = $clog2(DEPTH_BYTES)
) (
  input  logic          i_CLK,
  input  logic          i_WE,
  input  logic [AW-1:0] i_WADDR,
  input  logic [7:0]    i_WDATA,
  input  logic [AW-1:0] i_RADDR,
  output logic [7:0]    o_RDATA
);

  logic [7:0] r_mem [DEPTH_BYTES];

  always_ff @(posedge i_CLK) begin
    if (i_WE) r_mem[i_WADDR] <= i_WDATA;
  end

  assign o_RDATA = r_mem[i_RADDR];

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: byte-serial word fetch with a one-word hit buffer.
// Optional feature macro: IMEM_BOUNDS_CHECK_EN (flag misaligned/out-of-range PCs).
module imem_responder
  import imem_pkg::*;
#(
  parameter int DEPTH_BYTES = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic                           i_CLK,
  input  logic                           i_RESET,
  input  logic                           i_READ,
  input  logic [31:0]                    i_PC,
  output logic [31:0]                    o_INSTRUCTION,
  output logic                           o_BUSYWAIT,
  output logic                           o_ERROR,
  input  logic                           i_LOAD_EN,
  input  logic [$clog2(DEPTH_BYTES)-1:0] i_LOAD_ADDR,
  input  logic [7:0]                     i_LOAD_DATA
);

  localparam int         AW        = $clog2(DEPTH_BYTES);
  localparam logic [3:0] LAST_WAIT = 4'(WAIT_STATES);

  state_t        r_state;
  logic [AW-3:0] r_fetchWord;
  logic [1:0]    r_cnt;
  logic [3:0]    r_waitCnt;
  logic [31:0]   r_word;
  logic [31:0]   r_instr;
  logic [31:0]   r_bufPc;
  logic          r_bufValid;
  logic          r_loadHit;

  logic [31:0]   w_pcNorm;
  logic          w_illegal;
  logic          w_hit;
  logic          w_miss;
  logic [AW-3:0] w_reqWord;
  logic [AW-1:0] w_rdAddr;
  logic [7:0]    w_rdData;
  logic          w_loadInBuf;
  logic          w_loadInFetch;
  logic          w_lastWait;

`ifdef IMEM_BOUNDS_CHECK_EN
  assign w_pcNorm  = i_PC;
  assign w_illegal = (i_PC[1:0] != 2'b00) || (i_PC >= 32'(DEPTH_BYTES));
`else
  // Masking aligns down and wraps modulo the memory size in one step.
  assign w_pcNorm  = i_PC & 32'(DEPTH_BYTES - WORD_BYTES);
  assign w_illegal = 1'b0;
`endif

  assign w_reqWord  = w_pcNorm[AW-1:2];
  assign w_hit      = r_bufValid && (w_pcNorm == r_bufPc);
  assign w_miss     = i_READ && !w_hit && !w_illegal;
  assign w_lastWait = (r_waitCnt == LAST_WAIT);
  assign w_rdAddr   = (r_state == FETCH) ? {r_fetchWord, r_cnt} : {w_reqWord, 2'b00};

  assign w_loadInBuf   = i_LOAD_EN && (i_LOAD_ADDR[AW-1:2] == r_bufPc[AW-1:2]);
  assign w_loadInFetch = i_LOAD_EN &&
                         (i_LOAD_ADDR[AW-1:2] == ((r_state == FETCH) ? r_fetchWord : w_reqWord));

  assign o_INSTRUCTION = r_instr;
  assign o_ERROR       = !i_RESET && (r_state == IDLE) && i_READ && w_illegal;
  assign o_BUSYWAIT    = !i_RESET && ((r_state == FETCH) || w_miss);

  imem_byte_array #(
    .DEPTH_BYTES (DEPTH_BYTES),
    .AW          (AW)
  ) u_array (
    .i_CLK   (i_CLK),
    .i_WE    (i_LOAD_EN),
    .i_WADDR (i_LOAD_ADDR),
    .i_WDATA (i_LOAD_DATA),
    .i_RADDR (w_rdAddr),
    .o_RDATA (w_rdData)
  );

  // The request cycle doubles as the first cycle of byte slot 0, giving 4*(WAIT_STATES+1) stall.
  always_ff @(posedge i_CLK) begin
    if (i_RESET) begin
      r_state     <= IDLE;
      r_fetchWord <= '0;
      r_cnt       <= 2'd0;
      r_waitCnt   <= 4'd0;
      r_word      <= 32'h0;
      r_instr     <= 32'h0;
      r_bufPc     <= 32'h0;
      r_bufValid  <= 1'b0;
      r_loadHit   <= 1'b0;
    end else begin
      if (w_loadInBuf) r_bufValid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_miss) begin
            r_fetchWord <= w_reqWord;
            r_loadHit   <= w_loadInFetch;
            r_state     <= FETCH;
            if (LAST_WAIT == 4'd0) begin
              r_word    <= placeByte(32'h0, LANE0, w_rdData);
              r_cnt     <= 2'd1;
              r_waitCnt <= 4'd0;
            end else begin
              r_word    <= 32'h0;
              r_cnt     <= 2'd0;
              r_waitCnt <= 4'd1;
            end
          end
        end
        FETCH: begin
          if (w_loadInFetch) r_loadHit <= 1'b1;
          if (w_lastWait) begin
            r_waitCnt <= 4'd0;
            r_word    <= placeByte(r_word, r_cnt, w_rdData);
            r_cnt     <= r_cnt + 2'd1;
            // A load into the word being fetched leaves the result unbuffered.
            if (r_cnt == LANE3) begin
              r_instr    <= placeByte(r_word, r_cnt, w_rdData);
              r_bufPc    <= 32'({r_fetchWord, 2'b00});
              r_bufValid <= !(r_loadHit || w_loadInFetch);
              r_state    <= IDLE;
            end
          end else begin
            r_waitCnt <= r_waitCnt + 4'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder: one instance with no wait states, one with two.
module tb_imem_responder;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        READ, READ2;
  logic [31:0] PC, PC2;
  logic        LOAD_EN;
  logic [9:0]  LOAD_ADDR;
  logic [7:0]  LOAD_DATA;

  logic [31:0] instr, instr2;
  logic        busy, busy2, err, err2;

  int vectors    = 0;
  int miscompares = 0;
  int stall;

  always #5 CLK = ~CLK;

  imem_responder #(.DEPTH_BYTES(1024), .WAIT_STATES(0)) dut (
    .i_CLK         (CLK),
    .i_RESET       (RESET),
    .i_READ        (READ),
    .i_PC          (PC),
    .o_INSTRUCTION (instr),
    .o_BUSYWAIT    (busy),
    .o_ERROR       (err),
    .i_LOAD_EN     (LOAD_EN),
    .i_LOAD_ADDR   (LOAD_ADDR),
    .i_LOAD_DATA   (LOAD_DATA)
  );

  imem_responder #(.DEPTH_BYTES(1024), .WAIT_STATES(2)) dut2 (
    .i_CLK         (CLK),
    .i_RESET       (RESET),
    .i_READ        (READ2),
    .i_PC          (PC2),
    .o_INSTRUCTION (instr2),
    .o_BUSYWAIT    (busy2),
    .o_ERROR       (err2),
    .i_LOAD_EN     (LOAD_EN),
    .i_LOAD_ADDR   (LOAD_ADDR),
    .i_LOAD_DATA   (LOAD_DATA)
  );

  // Inputs change 2 time units after a rising edge; outputs are sampled 1 unit later.
  task automatic step();
    @(posedge CLK);
    #2;
  endtask

  task automatic applyStimulus(input logic rd, input logic [31:0] pc);
    READ = rd;
    PC   = pc;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic loadByte(input logic [9:0] addr, input logic [7:0] data);
    LOAD_EN   = 1'b1;
    LOAD_ADDR = addr;
    LOAD_DATA = data;
    step();
    LOAD_EN   = 1'b0;
  endtask

  // Counts consecutive BUSYWAIT cycles from the current one, bounded at 50.
  task automatic measureStall(input bit second, output int n);
    n = 0;
    while (((second ? busy2 : busy) === 1'b1) && (n < 50)) begin
      n++;
      step();
      #1;
    end
  endtask

  initial begin
    RESET = 1'b1; READ = 1'b1; PC = 32'h0; READ2 = 1'b0; PC2 = 32'h0;
    LOAD_EN = 1'b0; LOAD_ADDR = '0; LOAD_DATA = '0;
    step(); step();
    #1;
    checkOutput("reset_instr", instr, 32'h0);
    checkOutput("reset_busy", {31'b0, busy}, 32'h0);
    checkOutput("reset_error", {31'b0, err}, 32'h0);
    RESET = 1'b0;
    READ  = 1'b0;
    step();

    loadByte(10'd0, 8'h01); loadByte(10'd1, 8'h02);
    loadByte(10'd2, 8'h03); loadByte(10'd3, 8'h04);
    loadByte(10'd4, 8'hDD); loadByte(10'd5, 8'hCC);
    loadByte(10'd6, 8'hBB); loadByte(10'd7, 8'hAA);

    // Miss on word 0: busy in cycles 0..3, word visible in cycle 4.
    applyStimulus(1'b1, 32'h0);
    for (int c = 0; c < 4; c++) begin
      checkOutput($sformatf("miss0_busy_c%0d", c), {31'b0, busy}, 32'h1);
      step();
      #1;
    end
    checkOutput("miss0_busy_c4", {31'b0, busy}, 32'h0);
    checkOutput("miss0_instr", instr, 32'h04030201);

    for (int c = 0; c < 3; c++) begin
      step();
      #1;
      checkOutput($sformatf("hit0_busy_%0d", c), {31'b0, busy}, 32'h0);
      checkOutput($sformatf("hit0_instr_%0d", c), instr, 32'h04030201);
    end

    // Two wait states: 4 slots of 3 cycles each.
    step();
    READ2 = 1'b1;
    PC2   = 32'h4;
    #1;
    measureStall(1'b1, stall);
    checkOutput("ws2_stall", 32'(stall), 32'd12);
    checkOutput("ws2_instr", instr2, 32'hAABBCCDD);
    READ2 = 1'b0;

    // A load into the buffered word forces a refetch.
    step();
    LOAD_EN = 1'b1; LOAD_ADDR = 10'd3; LOAD_DATA = 8'hFF;
    #1;
    checkOutput("load_cycle_busy", {31'b0, busy}, 32'h0);
    step();
    LOAD_EN = 1'b0;
    #1;
    measureStall(1'b0, stall);
    checkOutput("reload_stall", 32'(stall), 32'd4);
    checkOutput("reload_instr", instr, 32'hFF030201);

    step();
    applyStimulus(1'b1, 32'h6);
`ifdef IMEM_BOUNDS_CHECK_EN
    checkOutput("pc6_error", {31'b0, err}, 32'h1);
    checkOutput("pc6_busy", {31'b0, busy}, 32'h0);
    step();
    #1;
    checkOutput("pc6_instr", instr, 32'hFF030201);
    applyStimulus(1'b1, 32'h400);
    checkOutput("pc400_error", {31'b0, err}, 32'h1);
    checkOutput("pc400_busy", {31'b0, busy}, 32'h0);
`else
    checkOutput("pc6_error", {31'b0, err}, 32'h0);
    measureStall(1'b0, stall);
    checkOutput("pc6_stall", 32'(stall), 32'd4);
    checkOutput("pc6_instr", instr, 32'hAABBCCDD);
    applyStimulus(1'b1, 32'h404);
    checkOutput("pc404_busy", {31'b0, busy}, 32'h0);
    checkOutput("pc404_instr", instr, 32'hAABBCCDD);
`endif

    // Buffer word 4 so that PC=0 is a miss in either build.
    step();
    applyStimulus(1'b1, 32'h4);
    measureStall(1'b0, stall);
    checkOutput("pc4_instr", instr, 32'hAABBCCDD);

    // Reset in cycle 2 of a PC=0 fetch discards it.
    step();
    applyStimulus(1'b1, 32'h0);
    checkOutput("abort_busy_c0", {31'b0, busy}, 32'h1);
    step();
    step();
    RESET = 1'b1;
    #1;
    checkOutput("abort_reset_busy", {31'b0, busy}, 32'h0);
    step();
    RESET = 1'b0;
    applyStimulus(1'b0, 32'h0);
    checkOutput("abort_instr", instr, 32'h0);
    checkOutput("abort_busy", {31'b0, busy}, 32'h0);
    step();
    applyStimulus(1'b1, 32'h0);
    measureStall(1'b0, stall);
    checkOutput("after_abort_stall", 32'(stall), 32'd4);
    checkOutput("after_abort_instr", instr, 32'hFF030201);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
